// File: rtl/lampFPU_pkg.sv
// rtl/lampFPU_pkg.sv - shared LAMP float constants, result type and rounding helper
package lampFPU_pkg;

   localparam int LAMP_FLOAT_E_DW = 8;
   localparam int LAMP_FLOAT_F_DW = 7;

   // Exponent/fraction pattern of infinity: all-ones exponent, zero fraction
   localparam logic [LAMP_FLOAT_E_DW+LAMP_FLOAT_F_DW-1:0] INF_E_F =
      {{LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};

   typedef struct packed {
      logic                       s;
      logic [LAMP_FLOAT_E_DW-1:0] e;
      logic [LAMP_FLOAT_F_DW-1:0] f;
   } lampFloat_t;

   // Round-to-nearest-even increment decision from lsb, guard and sticky
   function automatic logic FUNC_rndNearestEven(input logic lsb, input logic g, input logic st);
      return g & (st | lsb);
   endfunction

endpackage

// File: rtl/lampfpu_res_fifo.sv
// rtl/lampfpu_res_fifo.sv - DEPTH x WIDTH result FIFO with push/pop/flush and fill count
module lampfpu_res_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         popData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic             doPush;
   logic             doPop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign doPop   = pop & ~empty;
   // A pop in the same cycle frees the head slot, so a full FIFO can still accept
   assign doPush  = push & (~full | doPop);
   assign popData = mem[rdPtr];

   // Pointer and fill-count bookkeeping; flush wins over push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + CNT_W'(doPush) - CNT_W'(doPop);
      end
   end

   // Entry storage; when full, wrPtr equals rdPtr so push+pop overwrites the departing head
   always_ff @(posedge clk) begin
      if (doPush & ~flush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/lampfpu_sqrt_rndpack.sv
// rtl/lampfpu_sqrt_rndpack.sv - sqrt result round-to-nearest-even, pack and buffer; option macro LAMP_SQRT_RND_FLAGS_EN
module lampfpu_sqrt_rndpack
   import lampFPU_pkg::*;
#(
   parameter int E_DW  = LAMP_FLOAT_E_DW,
   parameter int F_DW  = LAMP_FLOAT_F_DW,
   parameter int DEPTH = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   input  logic                 s_i,
   input  logic [E_DW-1:0]      e_i,
   input  logic [F_DW+4:0]      f_i,
   input  logic                 isToRound_i,
   input  logic                 flush_i,
   output logic [E_DW+F_DW:0]   res_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic                 overrun_o
`ifdef LAMP_SQRT_RND_FLAGS_EN
   ,
   output logic [1:0]           flags_o
`endif
);

   localparam int RES_W = 1 + E_DW + F_DW;
   localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef LAMP_SQRT_RND_FLAGS_EN
   localparam int ENT_W = RES_W + 2;
`else
   localparam int ENT_W = RES_W;
`endif

   logic             lsb;
   logic             g;
   logic             st;
   logic             rndUp;
   logic [F_DW+1:0]  m;
   logic             carry;
   logic [E_DW-1:0]  rndE;
   logic [F_DW-1:0]  rndF;
   logic             ovf;
   logic [RES_W-1:0] packedRes;
   logic [ENT_W-1:0] pushData;
   logic [ENT_W-1:0] popData;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             pop;

   assign lsb   = f_i[3];
   assign g     = f_i[2];
   assign st    = f_i[1] | f_i[0];
   assign rndUp = isToRound_i & FUNC_rndNearestEven(lsb, g, st);

   // Carry bit of f_i is zero on legal input, so m[F_DW+1] flags a mantissa overflow
   assign m     = f_i[F_DW+4:3] + {{(F_DW+1){1'b0}}, rndUp};
   assign carry = m[F_DW+1];
   assign rndE  = carry ? (e_i + {{(E_DW-1){1'b0}}, 1'b1}) : e_i;
   // Renormalising shift on carry; those bits are all zero after a carry
   assign rndF  = carry ? m[F_DW:1] : m[F_DW-1:0];
   assign ovf   = isToRound_i & (&rndE);

   // Select rounded, infinity or bit-exact special value
   always_comb begin
      packedRes = {s_i, e_i, f_i[F_DW+2:3]};
      if (isToRound_i) begin
         if (ovf) packedRes = {s_i, {E_DW{1'b1}}, {F_DW{1'b0}}};
         else     packedRes = {s_i, rndE, rndF};
      end
   end

`ifdef LAMP_SQRT_RND_FLAGS_EN
   logic inexact;
   assign inexact  = isToRound_i & (g | st);
   assign pushData = {ovf, inexact, packedRes};
   assign flags_o  = empty ? 2'b00 : popData[RES_W+1:RES_W];
`else
   assign pushData = packedRes;
`endif

   assign pop = ~empty & ready_i;

   lampfpu_res_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .push     (valid_i),
      .pushData (pushData),
      .pop      (pop),
      .flush    (flush_i),
      .popData  (popData),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   // Sticky record of a result lost to a full FIFO with no pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           overrun_o <= 1'b0;
      else if (flush_i)                  overrun_o <= 1'b0;
      else if (valid_i & full & ~pop)    overrun_o <= 1'b1;
   end

   assign valid_o = ~empty;
   assign res_o   = empty ? '0 : popData[RES_W-1:0];
   assign busy_o  = (count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_lampfpu_sqrt_rndpack.sv
// tb/tb_lampfpu_sqrt_rndpack.sv - directed vector bench for lampfpu_sqrt_rndpack
module tb_lampfpu_sqrt_rndpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic        s_i;
   logic [7:0]  e_i;
   logic [11:0] f_i;
   logic        isToRound_i;
   logic        flush_i;
   logic [15:0] res_o;
   logic        valid_o;
   logic        ready_i;
   logic        busy_o;
   logic        overrun_o;
`ifdef LAMP_SQRT_RND_FLAGS_EN
   logic [1:0]  flags_o;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [11:0] f;
      logic        rnd;
      logic [15:0] res;
      logic [1:0]  flg;
   } vec_t;

   vec_t vecs[10];

   lampfpu_sqrt_rndpack #(.E_DW(8), .F_DW(7), .DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .s_i         (s_i),
      .e_i         (e_i),
      .f_i         (f_i),
      .isToRound_i (isToRound_i),
      .flush_i     (flush_i),
      .res_o       (res_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .overrun_o   (overrun_o)
`ifdef LAMP_SQRT_RND_FLAGS_EN
      ,
      .flags_o     (flags_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int i);
      s_i         = vecs[i].s;
      e_i         = vecs[i].e;
      f_i         = vecs[i].f;
      isToRound_i = vecs[i].rnd;
      valid_i     = 1'b1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b0, 8'd127, 12'b0_1_0000000_1_0_1, 1'b1, 16'h3F81, 2'b01};
      vecs[1] = '{1'b0, 8'd127, 12'b0_1_0000000_1_0_0, 1'b1, 16'h3F80, 2'b01};
      vecs[2] = '{1'b0, 8'd127, 12'b0_1_0000001_1_0_0, 1'b1, 16'h3F82, 2'b01};
      vecs[3] = '{1'b0, 8'd127, 12'b0_1_1111111_1_1_0, 1'b1, 16'h4000, 2'b01};
      vecs[4] = '{1'b0, 8'd254, 12'b0_1_1111111_1_1_0, 1'b1, 16'h7F80, 2'b11};
      vecs[5] = '{1'b0, 8'd255, 12'b0_1_1000000_0_0_1, 1'b0, 16'h7FC0, 2'b00};
      vecs[6] = '{1'b1, 8'd100, 12'b0_1_0101010_0_1_1, 1'b1, 16'hB22A, 2'b01};
      vecs[7] = '{1'b0, 8'd1,   12'b0_1_1111111_0_0_0, 1'b1, 16'h00FF, 2'b00};
      vecs[8] = '{1'b0, 8'd255, 12'b0_1_0000011_0_0_0, 1'b1, 16'h7F80, 2'b10};
      vecs[9] = '{1'b1, 8'd3,   12'b0_1_1111111_1_1_1, 1'b0, 16'h81FF, 2'b00};

      rst = 1'b1; valid_i = 1'b0; s_i = 1'b0; e_i = '0; f_i = '0;
      isToRound_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
      step; step;
      check("reset valid_o", valid_o, 0);
      check("reset res_o", res_o, 0);
      check("reset busy_o", busy_o, 0);
      check("reset overrun_o", overrun_o, 0);
      rst = 1'b0;
      step;

      // Table: push one vector, see it one edge later, it pops on the next edge
      for (int i = 0; i < 10; i++) begin
         drive(i);
         #1;
         check($sformatf("v%0d no bypass", i), valid_o, 0);
         step;
         check($sformatf("v%0d valid_o", i), valid_o, 1);
         check($sformatf("v%0d res_o", i), res_o, vecs[i].res);
`ifdef LAMP_SQRT_RND_FLAGS_EN
         check($sformatf("v%0d flags_o", i), flags_o, vecs[i].flg);
`endif
         valid_i = 1'b0;
         step;
         check($sformatf("v%0d drained", i), valid_o, 0);
`ifdef LAMP_SQRT_RND_FLAGS_EN
         check($sformatf("v%0d flags idle", i), flags_o, 0);
`endif
      end

      // Backpressure: A, B stored, C dropped
      ready_i = 1'b0;
      drive(0); step;
      check("bp busy after A", busy_o, 1);
      check("bp head A", res_o, 16'h3F81);
      drive(1); step;
      check("bp head stable", res_o, 16'h3F81);
      check("bp no overrun yet", overrun_o, 0);
      drive(2); step;
      check("bp overrun", overrun_o, 1);
      check("bp head after drop", res_o, 16'h3F81);
      valid_i = 1'b0; ready_i = 1'b1;
      #1;
      check("bp drain A", res_o, 16'h3F81);
      step;
      check("bp drain B valid", valid_o, 1);
      check("bp drain B", res_o, 16'h3F80);
      step;
      check("bp empty", valid_o, 0);
      check("bp busy clear", busy_o, 0);
      check("bp overrun sticky", overrun_o, 1);

      // Flush clears overrun
      flush_i = 1'b1; step; flush_i = 1'b0;
      check("flush overrun", overrun_o, 0);

      // Full FIFO with push+pop keeps two entries in order
      ready_i = 1'b0;
      drive(0); step;
      drive(1); step;
      ready_i = 1'b1;
      drive(2); step;
      check("pp head B", res_o, 16'h3F80);
      check("pp no overrun", overrun_o, 0);
      ready_i = 1'b0;
      drive(3); step;
      check("pp still full", overrun_o, 1);
      valid_i = 1'b0; ready_i = 1'b1;
      #1;
      check("pp order B", res_o, 16'h3F80);
      step;
      check("pp order C", res_o, 16'h3F82);
      step;
      check("pp empty", valid_o, 0);

      // Flush beats a simultaneous push
      ready_i = 1'b0;
      drive(4); step;
      check("fl loaded", valid_o, 1);
      drive(5); flush_i = 1'b1; step;
      flush_i = 1'b0; valid_i = 1'b0;
      check("fl empty", valid_o, 0);
      check("fl overrun clr", overrun_o, 0);
      check("fl res zero", res_o, 0);

      // Asynchronous reset mid-stream
      drive(6); step;
      drive(7); step;
      drive(8); step;
      valid_i = 1'b0;
      check("rst pre overrun", overrun_o, 1);
      #2 rst = 1'b1;
      #1;
      check("rst async valid_o", valid_o, 0);
      check("rst async res_o", res_o, 0);
      check("rst async busy_o", busy_o, 0);
      check("rst async overrun", overrun_o, 0);
      step;
      rst = 1'b0; ready_i = 1'b1;
      drive(9); step;
      valid_i = 1'b0;
      check("post rst res", res_o, 16'h81FF);
      step;
      check("post rst drained", valid_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
